// File: rtl/bus_xfer_ctrl.sv
// Register-bus transfer sequencer. Accepts transfer/clear commands over a
// valid/ready handshake and emits registered, glitch-free bus controls plus
// one-cycle load-enable / clear strobes for the downstream register bank.
module bus_xfer_ctrl #(
  parameter int unsigned NREG = 4,
  parameter int unsigned IDXW = 2,
  parameter int unsigned CNTW = 16
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_op,
  input  logic [IDXW-1:0] req_src,
  input  logic [IDXW-1:0] req_dst,
  output logic [IDXW-1:0] src_sel,
  output logic            bus_drive,
  output logic [NREG-1:0] load_en,
  output logic [NREG-1:0] reg_clr,
  output logic            done,
  output logic            err,
  output logic            busy,
  output logic [CNTW-1:0] xfer_count
);

  typedef enum logic [2:0] {StIdle, StDrive, StLoad, StClr, StFin} state_e;

  state_e          state_q, state_d;
  logic            cmd_op_q, cmd_op_d;
  logic [IDXW-1:0] cmd_src_q, cmd_src_d;
  logic [IDXW-1:0] cmd_dst_q, cmd_dst_d;
  logic            cmd_err_q, cmd_err_d;

  logic [IDXW-1:0] src_sel_q, src_sel_d;
  logic            bus_drive_q, bus_drive_d;
  logic [NREG-1:0] load_en_q, load_en_d;
  logic [NREG-1:0] reg_clr_q, reg_clr_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [CNTW-1:0] count_q, count_d;

  logic accept;
  logic dst_bad, src_bad;

  assign accept  = req_valid && (state_q == StIdle);
  assign dst_bad = int'(req_dst) >= int'(NREG);
  assign src_bad = int'(req_src) >= int'(NREG);

  // Next-state sequencing and command latching.
  always_comb begin
    state_d   = state_q;
    cmd_op_d  = cmd_op_q;
    cmd_src_d = cmd_src_q;
    cmd_dst_d = cmd_dst_q;
    cmd_err_d = cmd_err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cmd_op_d  = req_op;
          cmd_src_d = req_src;
          cmd_dst_d = req_dst;
          cmd_err_d = dst_bad || (!req_op && src_bad);
          if (dst_bad || (!req_op && src_bad)) begin
            state_d = StFin;
          end else if (req_op) begin
            state_d = StClr;
          end else if (req_src == req_dst) begin
            // Legal no-op: completes successfully without any strobe.
            state_d = StFin;
          end else begin
            state_d = StDrive;
          end
        end
      end
      StDrive: state_d = StLoad;
      StLoad:  state_d = StFin;
      StClr:   state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the upcoming state so the flops line up with state_q.
  always_comb begin
    src_sel_d   = src_sel_q;
    bus_drive_d = 1'b0;
    load_en_d   = '0;
    reg_clr_d   = '0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    count_d     = count_q;
    if (state_d == StDrive || state_d == StLoad) begin
      src_sel_d   = cmd_src_d;
      bus_drive_d = 1'b1;
    end
    if (state_d == StLoad) load_en_d = NREG'(1) << cmd_dst_d;
    if (state_d == StClr)  reg_clr_d = NREG'(1) << cmd_dst_d;
    if (state_d == StFin) begin
      done_d = 1'b1;
      err_d  = cmd_err_d;
    end
    // Count on the edge leaving FIN; wraps naturally at the counter width.
    if (state_q == StFin && !cmd_err_q) count_d = count_q + CNTW'(1);
  end

  // State, latched command and registered outputs.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q     <= StIdle;
      cmd_op_q    <= 1'b0;
      cmd_src_q   <= '0;
      cmd_dst_q   <= '0;
      cmd_err_q   <= 1'b0;
      src_sel_q   <= '0;
      bus_drive_q <= 1'b0;
      load_en_q   <= '0;
      reg_clr_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_op_q    <= cmd_op_d;
      cmd_src_q   <= cmd_src_d;
      cmd_dst_q   <= cmd_dst_d;
      cmd_err_q   <= cmd_err_d;
      src_sel_q   <= src_sel_d;
      bus_drive_q <= bus_drive_d;
      load_en_q   <= load_en_d;
      reg_clr_q   <= reg_clr_d;
      done_q      <= done_d;
      err_q       <= err_d;
      count_q     <= count_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign src_sel    = src_sel_q;
  assign bus_drive  = bus_drive_q;
  assign load_en    = load_en_q;
  assign reg_clr    = reg_clr_q;
  assign done       = done_q;
  assign err        = err_q;
  assign xfer_count = count_q;

  // cmd_op is kept for completeness of the latched command; routing is fixed at accept.
  logic unused_op;
  assign unused_op = cmd_op_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench for bus_xfer_ctrl: instance A (NREG=4, CNTW=16) with a model of
// the downstream register bank, instance B (NREG=3, CNTW=4) for errors and wrap.
module tb_bus_xfer_ctrl;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       req_op = 1'b0;
  logic [1:0] req_src = '0, req_dst = '0;

  logic        a_ready, a_bus, a_done, a_err, a_busy;
  logic [1:0]  a_sel;
  logic [3:0]  a_load, a_clr;
  logic [15:0] a_cnt;

  logic        b_ready, b_bus, b_done, b_err, b_busy;
  logic [1:0]  b_sel;
  logic [2:0]  b_load, b_clr;
  logic [3:0]  b_cnt;

  int checks = 0;
  int failures = 0;

  // Downstream enable/clear register bank fed by instance A.
  logic [7:0] mregs [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};

  always #5 clock = ~clock;

  bus_xfer_ctrl #(.NREG(4), .IDXW(2), .CNTW(16)) dut_a (
    .clock(clock), .clear(clear), .req_valid(valid_a), .req_ready(a_ready),
    .req_op(req_op), .req_src(req_src), .req_dst(req_dst), .src_sel(a_sel),
    .bus_drive(a_bus), .load_en(a_load), .reg_clr(a_clr), .done(a_done),
    .err(a_err), .busy(a_busy), .xfer_count(a_cnt)
  );

  bus_xfer_ctrl #(.NREG(3), .IDXW(2), .CNTW(4)) dut_b (
    .clock(clock), .clear(clear), .req_valid(valid_b), .req_ready(b_ready),
    .req_op(req_op), .req_src(req_src), .req_dst(req_dst), .src_sel(b_sel),
    .bus_drive(b_bus), .load_en(b_load), .reg_clr(b_clr), .done(b_done),
    .err(b_err), .busy(b_busy), .xfer_count(b_cnt)
  );

  // Register-bank model: load captures the bus, clear zeroes.
  always @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (a_clr[i]) mregs[i] <= 8'h00;
      else if (a_load[i]) mregs[i] <= a_bus ? mregs[a_sel] : 8'hEE;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    repeat (2) tick();
    checks++; if (a_cnt !== 16'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", a_cnt); end
    checks++; if ({a_bus, a_load, a_clr, a_done, a_err, a_sel} !== 12'd0) begin
      failures++; $display("FAIL rst_outputs got=%b exp=0", {a_bus, a_load, a_clr, a_done, a_err, a_sel}); end
    clear = 1'b1;
    tick();
    // Start a transfer 2 -> 0 and abort it mid-LOAD.
    req_op = 1'b0; req_src = 2'd2; req_dst = 2'd0; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    tick();
    checks++; if (a_load !== 4'b0001) begin failures++; $display("FAIL rst_preload got=%b exp=0001", a_load); end
    #2 clear = 1'b0;
    #1;
    checks++; if ({a_load, a_bus} !== 5'd0) begin
      failures++; $display("FAIL rst_async got=%b exp=00000", {a_load, a_bus}); end
    tick();
    #3 clear = 1'b1;
    tick();
    checks++; if ({a_busy, a_ready, a_done} !== 3'b010) begin
      failures++; $display("FAIL rst_release got=%b exp=010", {a_busy, a_ready, a_done}); end
    checks++; if (a_cnt !== 16'd0) begin failures++; $display("FAIL rst_count2 got=%0d exp=0", a_cnt); end
    checks++; if (mregs[0] !== 8'hA0) begin failures++; $display("FAIL rst_noload got=%h exp=a0", mregs[0]); end
  endtask

  task automatic test_transfer();
    req_op = 1'b0; req_src = 2'd1; req_dst = 2'd3; valid_a = 1'b1;
    tick();
    valid_a = 1'b0; req_src = 2'd0; req_dst = 2'd0;
    checks++; if ({a_sel, a_bus, a_load, a_busy, a_ready} !== 9'b01_1_0000_10) begin
      failures++; $display("FAIL xfer_drive got=%b exp=011000010", {a_sel, a_bus, a_load, a_busy, a_ready}); end
    tick();
    checks++; if ({a_sel, a_bus, a_load, a_done} !== 8'b01_1_1000_0) begin
      failures++; $display("FAIL xfer_load got=%b exp=01110000", {a_sel, a_bus, a_load, a_done}); end
    tick();
    checks++; if ({a_done, a_err, a_load, a_bus} !== 7'b10_0000_0) begin
      failures++; $display("FAIL xfer_fin got=%b exp=1000000", {a_done, a_err, a_load, a_bus}); end
    tick();
    checks++; if (a_cnt !== 16'd1 || a_done !== 1'b0) begin
      failures++; $display("FAIL xfer_count got=%0d/%b exp=1/0", a_cnt, a_done); end
    checks++; if (mregs[3] !== 8'hA1) begin failures++; $display("FAIL xfer_data got=%h exp=a1", mregs[3]); end
  endtask

  task automatic test_clear();
    req_op = 1'b1; req_src = 2'd3; req_dst = 2'd2; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    checks++; if ({a_clr, a_load, a_bus, a_done} !== 10'b0100_0000_0_0) begin
      failures++; $display("FAIL clr_strobe got=%b exp=0100000000", {a_clr, a_load, a_bus, a_done}); end
    tick();
    checks++; if ({a_done, a_err, a_clr, a_load} !== 10'b10_0000_0000) begin
      failures++; $display("FAIL clr_fin got=%b exp=1000000000", {a_done, a_err, a_clr, a_load}); end
    tick();
    checks++; if (a_cnt !== 16'd2) begin failures++; $display("FAIL clr_count got=%0d exp=2", a_cnt); end
    checks++; if (mregs[2] !== 8'h00) begin failures++; $display("FAIL clr_data got=%h exp=00", mregs[2]); end
  endtask

  task automatic test_err_noop();
    req_op = 1'b0; req_src = 2'd0; req_dst = 2'd3; valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    checks++; if ({b_done, b_err, b_load, b_clr, b_bus} !== 9'b11_000_000_0) begin
      failures++; $display("FAIL err_fin got=%b exp=110000000", {b_done, b_err, b_load, b_clr, b_bus}); end
    tick();
    checks++; if (b_cnt !== 4'd0 || b_done !== 1'b0) begin
      failures++; $display("FAIL err_count got=%0d/%b exp=0/0", b_cnt, b_done); end
    req_src = 2'd1; req_dst = 2'd1; valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    checks++; if ({b_done, b_err, b_load, b_clr, b_bus} !== 9'b10_000_000_0) begin
      failures++; $display("FAIL noop_fin got=%b exp=100000000", {b_done, b_err, b_load, b_clr, b_bus}); end
    tick();
    checks++; if (b_cnt !== 4'd1) begin failures++; $display("FAIL noop_count got=%0d exp=1", b_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] srcs [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    logic [1:0] dsts [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
    int accepts = 0, dones = 0, cyc = 0, last_acc = 0;
    logic pending;
    req_op = 1'b0; req_src = srcs[0]; req_dst = dsts[0]; valid_a = 1'b1;
    while (dones < 5 && cyc < 40) begin
      pending = a_ready && valid_a;
      tick();
      cyc++;
      if (pending) begin
        if (accepts > 0) begin
          checks++; if (cyc - last_acc !== 4) begin
            failures++; $display("FAIL b2b_interval got=%0d exp=4", cyc - last_acc); end
        end
        last_acc = cyc;
        accepts++;
        if (accepts < 5) begin req_src = srcs[accepts]; req_dst = dsts[accepts]; end
        else valid_a = 1'b0;
      end
      if (a_done) dones++;
      if (a_busy && a_ready) begin
        checks++; failures++; $display("FAIL b2b_ready got=1 exp=0 at cycle %0d", cyc);
      end
    end
    valid_a = 1'b0;
    checks++; if (dones !== 5 || accepts !== 5) begin
      failures++; $display("FAIL b2b_done got=%0d/%0d exp=5/5", dones, accepts); end
    tick();
    checks++; if (a_cnt !== 16'd7) begin failures++; $display("FAIL b2b_count got=%0d exp=7", a_cnt); end
  endtask

  task automatic test_wrap();
    #3 clear = 1'b0;
    tick();
    #3 clear = 1'b1;
    tick();
    req_op = 1'b0; req_src = 2'd0; req_dst = 2'd0;
    for (int k = 1; k <= 17; k++) begin
      valid_b = 1'b1;
      tick();
      valid_b = 1'b0;
      tick();
      if (k == 15) begin
        checks++; if (b_cnt !== 4'd15) begin failures++; $display("FAIL wrap_15 got=%0d exp=15", b_cnt); end
      end else if (k == 16) begin
        checks++; if (b_cnt !== 4'd0) begin failures++; $display("FAIL wrap_16 got=%0d exp=0", b_cnt); end
      end else if (k == 17) begin
        checks++; if (b_cnt !== 4'd1) begin failures++; $display("FAIL wrap_17 got=%0d exp=1", b_cnt); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_transfer();
    test_clear();
    test_err_noop();
    test_back_to_back();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_xfer_ctrl.md
Name: bus_xfer_ctrl

Overview:
Sequencer that drives the shared register bus. It accepts register-transfer and register-clear commands over a valid/ready handshake. For each command it generates the source-select and bus-drive controls and a one-cycle load-enable or clear strobe. These strobes go to the bank of enable/clear flip-flop registers directly downstream, whose `en` and `clear` inputs are wired from `load_en[i]` and `reg_clr[i]`.

Parameters:
NREG, 4, number of registers on the bus (2..16)
IDXW, 2, width of register index fields (must satisfy 2**IDXW >= NREG)
CNTW, 16, width of completed-transfer counter

Ports:
clock  input  1  system clock, all state on rising edge
clear  input  1  asynchronous reset, active-low (0 = reset)
req_valid  input  1  command present
req_ready  output  1  controller can accept command this cycle
req_op  input  1  0 = transfer src->dst, 1 = clear dst
req_src  input  IDXW  source register index (ignored for clear)
req_dst  input  IDXW  destination register index
src_sel  output  IDXW  bus mux select
bus_drive  output  1  source register output enabled onto bus
load_en  output  NREG  one-hot load enable to destination register
reg_clr  output  NREG  one-hot synchronous clear to destination register
done  output  1  one-cycle completion pulse
err  output  1  qualifies done: command rejected
busy  output  1  controller not in IDLE
xfer_count  output  CNTW  number of successful commands since reset

Behaviour:
- Reset (`clear`=0, asynchronous): state=IDLE, src_sel=0, bus_drive=0, load_en=0, reg_clr=0, done=0, err=0, xfer_count=0. All outputs are forced to these values immediately, without waiting for a clock edge.
- `req_ready` = (state==IDLE), combinational from state. Accept happens on a clock edge where req_valid && req_ready.
- Command fields are latched on accept into cmd_op/cmd_src/cmd_dst. Inputs are don't-care after accept.
- States: IDLE, DRIVE, LOAD, CLR, FIN.
- IDLE -> on accept:
  - dst >= NREG, or (op=0 and src >= NREG) -> FIN with err pending.
  - op=1 -> CLR.
  - op=0 and src==dst -> FIN. This is a legal no-op: no enables, counted as success.
  - Otherwise -> DRIVE.
- DRIVE (1 cycle): src_sel=cmd_src, bus_drive=1, load_en=0. This gives bus settle time. -> LOAD.
- LOAD (1 cycle): src_sel=cmd_src, bus_drive=1, load_en=1<<cmd_dst. The destination register captures on the edge ending this cycle. -> FIN.
- CLR (1 cycle): reg_clr=1<<cmd_dst, bus_drive=0. -> FIN.
- FIN (1 cycle): done=1; err=1 if the command was rejected, else 0. xfer_count increments on the edge leaving FIN when err=0; it wraps at 2**CNTW-1 -> 0. -> IDLE.
- All strobe outputs are registered (decoded from state and latched fields, glitch-free). Outside their state: load_en=0, reg_clr=0, bus_drive=0, done=0, err=0. src_sel holds its last value.
- load_en and reg_clr are never both nonzero. At most one bit of each is set.
- Latency, accept edge to done high:
  - Transfer: 3 cycles (DRIVE, LOAD, FIN).
  - Clear: 2 cycles.
  - No-op or error: 1 cycle.
- Back-to-back: the next accept is possible on the edge leaving FIN+1 (IDLE cycle). Maximum throughput is one transfer per 4 cycles.
- busy = (state != IDLE).
- Reset asserted mid-command aborts the command: no partial strobes remain, no done is issued, and the count is not incremented.
- req_valid dropping while in IDLE without a handshake has no effect.

Test Plan:
- Reset: hold clear=0 mid-LOAD of a transfer -> load_en=0, bus_drive=0 immediately, without a clock edge. After release, busy=0, req_ready=1, xfer_count=0.
- Transfer: NREG=4, send op=0 src=1 dst=3 -> DRIVE cycle src_sel=1 bus_drive=1; LOAD cycle load_en=4'b1000; FIN cycle done=1 err=0; xfer_count=1. The downstream flip-flop on register 3 holds register 1's value.
- Clear: send op=1 dst=2 -> reg_clr=4'b0100 for exactly one cycle, done 2 cycles after accept, err=0, load_en stays 0.
- Error and no-op: NREG=3, dst=3 -> done=1 err=1 one cycle after accept, no strobes, count unchanged. Then src=dst=1 -> done err=0, no strobes, count+1.
- Back-to-back: hold req_valid=1 with 5 transfers queued by the bench -> req_ready low while busy. Accepts occur every 4 cycles; 5 done pulses; xfer_count=5.
- Wrap: CNTW=4, 17 successful commands -> xfer_count reads 15 then 0 then 1.
